zoom_request_controller: RTL and testbench

//  Sequences the image-scaling engine from board inputs. Algorithm switches
//  (one-hot SW[3:0]) and zoom-in/zoom-out buttons are validated; valid requests

---
 rtl/zoom_request_controller.sv | 268 ++++++++++++++++++++++++++
 tb/tb_zoom_request_controller.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zoom_request_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : zoom_request_controller
//  Purpose  : Validates algorithm switches and zoom buttons from the board and
//             sequences one start/done transaction with the image scaler for
//             every accepted request. Raises switch, zoom and timeout errors
//             for the 7-segment message display.
//  Ports    :
//    clk, reset                - clock, asynchronous active-high reset
//    sw_algo[3:0]              - one-hot algorithm switches (NN, PR, DEC, BA)
//    btn_zoom_in/btn_zoom_out  - debounced level buttons, rising edge acts
//    scaler_done               - 1-cycle completion pulse from scaler
//    scale_start               - 1-cycle start pulse to scaler
//    algorithm_select[1:0]     - 00 NN, 01 PR, 10 DEC, 11 BA
//    zoom_level[LVL_W-1:0]     - signed zoom level, 2^level scale
//    busy                      - transaction in flight
//    invalid_zoom_error        - rejected request, held for ERR_HOLD_CYCLES
//    multiple_switches_error   - more than one switch up (registered)
//    no_switch_selected_error  - no switch up (registered)
//    scale_timeout_error       - scaler never answered, sticky
//  Revision : 1.0 - initial release
// ============================================================================
module zoom_request_controller #(
  parameter int MAX_LVL         = 2,
  parameter int LVL_W           = 3,
  parameter int ERR_HOLD_CYCLES = 100_000_000,
  parameter int TIMEOUT_CYCLES  = 50_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              sw_algo,
  input  logic                    btn_zoom_in,
  input  logic                    btn_zoom_out,
  input  logic                    scaler_done,
  output logic                    scale_start,
  output logic [1:0]              algorithm_select,
  output logic signed [LVL_W-1:0] zoom_level,
  output logic                    busy,
  output logic                    invalid_zoom_error,
  output logic                    multiple_switches_error,
  output logic                    no_switch_selected_error,
  output logic                    scale_timeout_error
);

  localparam int c_HOLD_W = $clog2(ERR_HOLD_CYCLES + 1);
  localparam int c_TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [c_HOLD_W-1:0]     c_HOLD_LAST = c_HOLD_W'(ERR_HOLD_CYCLES - 1);
  localparam logic [c_TO_W-1:0]       c_TO_LAST   = c_TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic signed [LVL_W-1:0] c_MAX_LVL   = LVL_W'(MAX_LVL);
  localparam logic signed [LVL_W-1:0] c_MIN_LVL   = LVL_W'(-MAX_LVL);
  localparam logic signed [LVL_W-1:0] c_ZERO      = '0;
  localparam logic signed [LVL_W-1:0] c_ONE       = LVL_W'(1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic                    r_btn_in_q;
  logic                    r_btn_out_q;
  logic [c_HOLD_W-1:0]     r_hold_cnt;
  logic [c_TO_W-1:0]       r_wait_cnt;

  logic                    w_edge_in;
  logic                    w_edge_out;
  logic                    w_sw_multi;
  logic                    w_sw_none;
  logic                    w_sw_bad;
  logic [1:0]              w_cand;
  logic                    w_cand_up;
  logic                    w_lvl_pos;
  logic                    w_lvl_neg;
  logic                    w_in_ok;
  logic                    w_out_ok;
  logic                    w_compat;
  logic                    w_latch;
  logic                    w_err_set;
  logic                    w_timeout_set;
  logic signed [LVL_W-1:0] w_level_next;

  // --------------------------------------------------------------------------
  // Button edge detection. History resets to 1 so a button held through
  // reset release does not look like a fresh press.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_btn_in_q  <= 1'b1;
      r_btn_out_q <= 1'b1;
    end else begin
      r_btn_in_q  <= btn_zoom_in;
      r_btn_out_q <= btn_zoom_out;
    end
  end

  assign w_edge_in  = btn_zoom_in  & ~r_btn_in_q;
  assign w_edge_out = btn_zoom_out & ~r_btn_out_q;

  // --------------------------------------------------------------------------
  // Switch validation and candidate algorithm decode
  // --------------------------------------------------------------------------
  assign w_sw_multi = ((sw_algo & (sw_algo - 4'd1)) != 4'd0);
  assign w_sw_none  = (sw_algo == 4'd0);
  // The current switch state is included alongside the registered flags so
  // an ambiguous candidate is never acted on during the flag's latency cycle.
  assign w_sw_bad   = w_sw_multi | w_sw_none |
                      multiple_switches_error | no_switch_selected_error;

  always_comb begin
    w_cand = 2'b00;
    case (sw_algo)
      4'b0001: w_cand = 2'b00;
      4'b0010: w_cand = 2'b01;
      4'b0100: w_cand = 2'b10;
      4'b1000: w_cand = 2'b11;
      default: w_cand = 2'b00;
    endcase
  end

  // NN and PR are upscalers, DEC and BA are downscalers.
  assign w_cand_up = ~w_cand[1];
  assign w_lvl_pos = (zoom_level > c_ZERO);
  assign w_lvl_neg = (zoom_level < c_ZERO);

  // Steps back toward 1x are allowed with any algorithm.
  assign w_in_ok  = w_lvl_neg | (w_cand_up & (zoom_level < c_MAX_LVL));
  assign w_out_ok = w_lvl_pos | (~w_cand_up & (zoom_level > c_MIN_LVL));

  // Level 0 accepts every algorithm; otherwise direction must match.
  assign w_compat = (w_lvl_pos & w_cand_up) | (w_lvl_neg & ~w_cand_up) |
                    (~w_lvl_pos & ~w_lvl_neg);

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // --------------------------------------------------------------------------
  // FSM next state and outputs. In IDLE the request rules are evaluated in
  // priority order; the first matching rule decides the action.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next  = r_state;
    w_latch       = 1'b0;
    w_err_set     = 1'b0;
    w_timeout_set = 1'b0;
    w_level_next  = zoom_level;
    scale_start   = 1'b0;
    busy          = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_sw_bad) begin
          // Switches unusable: buttons are ignored silently.
        end else if (w_edge_in && w_edge_out) begin
          w_err_set = 1'b1;
        end else if (w_edge_in && w_in_ok) begin
          w_level_next = zoom_level + c_ONE;
          w_latch      = 1'b1;
          w_state_next = S_START;
        end else if (w_edge_out && w_out_ok) begin
          w_level_next = zoom_level - c_ONE;
          w_latch      = 1'b1;
          w_state_next = S_START;
        end else if (w_edge_in || w_edge_out) begin
          w_err_set = 1'b1;
        end else if ((w_cand != algorithm_select) && w_compat) begin
          // Algorithm change alone re-runs the scaler at the current level.
          w_latch      = 1'b1;
          w_state_next = S_START;
        end else if (!w_compat) begin
          // Keeps re-arming the hold timer for as long as the switch
          // disagrees with the current zoom direction.
          w_err_set = 1'b1;
        end
      end
      S_START: begin
        scale_start  = 1'b1;
        busy         = 1'b1;
        w_state_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        busy = 1'b1;
        if (scaler_done) begin
          w_state_next = S_IDLE;
        end else if (r_wait_cnt == c_TO_LAST) begin
          w_timeout_set = 1'b1;
          w_state_next  = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Latched request: level and algorithm only move on the IDLE->START edge,
  // so they are stable for the whole transaction.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      algorithm_select <= 2'b00;
      zoom_level       <= c_ZERO;
    end else if (w_latch) begin
      algorithm_select <= w_cand;
      zoom_level       <= w_level_next;
    end
  end

  // --------------------------------------------------------------------------
  // Invalid-zoom flag with hold timer (ERR_HOLD_CYCLES-1 down to 0)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      invalid_zoom_error <= 1'b0;
      r_hold_cnt         <= '0;
    end else if (w_latch) begin
      invalid_zoom_error <= 1'b0;
      r_hold_cnt         <= '0;
    end else if (w_err_set) begin
      invalid_zoom_error <= 1'b1;
      r_hold_cnt         <= c_HOLD_LAST;
    end else if (invalid_zoom_error) begin
      if (r_hold_cnt == '0) invalid_zoom_error <= 1'b0;
      else                  r_hold_cnt         <= r_hold_cnt - 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Scaler timeout: counts WAIT_DONE cycles; flag is sticky until next start.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait_cnt          <= '0;
      scale_timeout_error <= 1'b0;
    end else begin
      if (r_state == S_START)          r_wait_cnt <= '0;
      else if (r_state == S_WAIT_DONE) r_wait_cnt <= r_wait_cnt + 1'b1;

      if (w_latch)            scale_timeout_error <= 1'b0;
      else if (w_timeout_set) scale_timeout_error <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Registered switch error flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      multiple_switches_error  <= 1'b0;
      no_switch_selected_error <= 1'b0;
    end else begin
      multiple_switches_error  <= w_sw_multi;
      no_switch_selected_error <= w_sw_none;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_zoom_request_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_zoom_request_controller
//  Purpose  : Directed, self-checking bench. Expected start transactions are
//             queued by the stimulus; a monitor pops and compares them on each
//             scale_start pulse. Flag and status checks are made inline.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_zoom_request_controller;

  localparam int MAX_LVL         = 2;
  localparam int LVL_W           = 3;
  localparam int ERR_HOLD_CYCLES = 16;
  localparam int TIMEOUT_CYCLES  = 32;

  logic                    clk;
  logic                    reset;
  logic [3:0]              sw_algo;
  logic                    btn_zoom_in;
  logic                    btn_zoom_out;
  logic                    scaler_done;
  logic                    scale_start;
  logic [1:0]              algorithm_select;
  logic signed [LVL_W-1:0] zoom_level;
  logic                    busy;
  logic                    invalid_zoom_error;
  logic                    multiple_switches_error;
  logic                    no_switch_selected_error;
  logic                    scale_timeout_error;

  zoom_request_controller #(
    .MAX_LVL         (MAX_LVL),
    .LVL_W           (LVL_W),
    .ERR_HOLD_CYCLES (ERR_HOLD_CYCLES),
    .TIMEOUT_CYCLES  (TIMEOUT_CYCLES)
  ) dut (
    .clk                      (clk),
    .reset                    (reset),
    .sw_algo                  (sw_algo),
    .btn_zoom_in              (btn_zoom_in),
    .btn_zoom_out             (btn_zoom_out),
    .scaler_done              (scaler_done),
    .scale_start              (scale_start),
    .algorithm_select         (algorithm_select),
    .zoom_level               (zoom_level),
    .busy                     (busy),
    .invalid_zoom_error       (invalid_zoom_error),
    .multiple_switches_error  (multiple_switches_error),
    .no_switch_selected_error (no_switch_selected_error),
    .scale_timeout_error      (scale_timeout_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]       algo;
    logic signed [2:0] lvl;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void check(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Scoreboard monitor: every start pulse must match the next queued request.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (scale_start === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_start: got start pulse, required none (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          check("start_algo", int'(algorithm_select), int'(e.algo));
          check("start_level", int'(zoom_level), int'(e.lvl));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_start(logic [1:0] algo, int lvl);
    exp_t e;
    e.algo = algo;
    e.lvl  = 3'(lvl);
    exp_q.push_back(e);
  endtask

  // One-cycle press; returns just after the edge that sampled it.
  task automatic press_in();
    btn_zoom_in = 1'b1;
    tick(1);
    btn_zoom_in = 1'b0;
  endtask

  task automatic press_out();
    btn_zoom_out = 1'b1;
    tick(1);
    btn_zoom_out = 1'b0;
  endtask

  // Called while in START: checks pulse width and busy, then completes.
  task automatic finish_txn();
    check("start_pulse", int'(scale_start), 1);
    check("busy_start", int'(busy), 1);
    tick(1);
    check("start_one_cycle", int'(scale_start), 0);
    check("busy_wait", int'(busy), 1);
    scaler_done = 1'b1;
    tick(1);
    scaler_done = 1'b0;
    check("busy_after_done", int'(busy), 0);
  endtask

  initial begin
    int n;
    reset        = 1'b1;
    sw_algo      = 4'b0001;
    btn_zoom_in  = 1'b0;
    btn_zoom_out = 1'b0;
    scaler_done  = 1'b0;
    tick(3);

    // Reset state
    check("rst_algo", int'(algorithm_select), 0);
    check("rst_level", int'(zoom_level), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_start", int'(scale_start), 0);
    check("rst_invalid", int'(invalid_zoom_error), 0);
    check("rst_timeout", int'(scale_timeout_error), 0);
    reset = 1'b0;
    tick(3);

    // NN zoom in: 0 -> +1
    expect_start(2'b00, 1);
    press_in();
    finish_txn();

    // Back to 0, then choosing DEC at level 0 re-runs the scaler
    expect_start(2'b00, 0);
    press_out();
    finish_txn();
    expect_start(2'b10, 0);
    sw_algo = 4'b0100;
    tick(1);
    finish_txn();

    // DEC zoom in at level 0 is invalid; flag held 16 cycles
    press_in();
    check("dec_in_invalid", int'(invalid_zoom_error), 1);
    check("dec_in_no_busy", int'(busy), 0);
    check("dec_in_level", int'(zoom_level), 0);
    tick(15);
    check("hold_last_cycle", int'(invalid_zoom_error), 1);
    tick(1);
    check("hold_expired", int'(invalid_zoom_error), 0);

    // DEC zoom out: 0 -> -1 -> -2, then -2 out is invalid
    expect_start(2'b10, -1);
    press_out();
    finish_txn();
    expect_start(2'b10, -2);
    press_out();
    finish_txn();
    press_out();
    check("min_out_invalid", int'(invalid_zoom_error), 1);
    tick(2);
    // Step toward 1x is valid and clears the error on START
    expect_start(2'b10, -1);
    press_in();
    check("start_clears_invalid", int'(invalid_zoom_error), 0);
    finish_txn();
    expect_start(2'b10, 0);
    press_in();
    finish_txn();

    // NN chosen at 0, climb to +2, +3 is invalid, step down to +1
    expect_start(2'b00, 0);
    sw_algo = 4'b0001;
    tick(1);
    finish_txn();
    expect_start(2'b00, 1);
    press_in();
    finish_txn();
    expect_start(2'b00, 2);
    press_in();
    finish_txn();
    press_in();
    check("max_in_invalid", int'(invalid_zoom_error), 1);
    check("max_in_level", int'(zoom_level), 2);
    tick(2);
    expect_start(2'b00, 1);
    press_out();
    finish_txn();

    // BA at +1 is incompatible: error held beyond the hold time
    sw_algo = 4'b1000;
    tick(1);
    check("incompat_invalid", int'(invalid_zoom_error), 1);
    tick(20);
    check("incompat_held", int'(invalid_zoom_error), 1);
    check("incompat_algo", int'(algorithm_select), 0);
    sw_algo = 4'b0001;
    tick(20);
    check("incompat_released", int'(invalid_zoom_error), 0);

    // Switch errors with one cycle latency; buttons ignored
    sw_algo = 4'b0011;
    #1;
    check("multi_latency", int'(multiple_switches_error), 0);
    tick(1);
    check("multi_set", int'(multiple_switches_error), 1);
    check("multi_none_clear", int'(no_switch_selected_error), 0);
    press_in();
    tick(1);
    check("multi_no_invalid", int'(invalid_zoom_error), 0);
    check("multi_level", int'(zoom_level), 1);
    sw_algo = 4'b0000;
    tick(1);
    check("none_set", int'(no_switch_selected_error), 1);
    check("none_multi_clear", int'(multiple_switches_error), 0);
    sw_algo = 4'b0001;
    tick(2);
    check("sw_ok_none", int'(no_switch_selected_error), 0);

    // Drop during WAIT_DONE, then timeout after 32 cycles
    expect_start(2'b00, 0);
    press_out();
    tick(1);
    btn_zoom_in = 1'b1;
    n = 0;
    while (busy && n < 60) begin
      tick(1);
      n++;
      if (n == 1) btn_zoom_in = 1'b0;
    end
    check("timeout_cycles", n, TIMEOUT_CYCLES);
    check("timeout_flag", int'(scale_timeout_error), 1);
    check("timeout_no_invalid", int'(invalid_zoom_error), 0);
    check("timeout_level", int'(zoom_level), 0);
    tick(5);
    check("timeout_sticky", int'(scale_timeout_error), 1);
    expect_start(2'b00, 1);
    press_in();
    check("timeout_cleared", int'(scale_timeout_error), 0);
    finish_txn();

    // Reset during WAIT_DONE with button held through release
    expect_start(2'b00, 2);
    press_in();
    tick(1);
    check("pre_reset_busy", int'(busy), 1);
    btn_zoom_in = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_level", int'(zoom_level), 0);
    check("mid_rst_algo", int'(algorithm_select), 0);
    check("mid_rst_start", int'(scale_start), 0);
    tick(2);
    reset = 1'b0;
    tick(5);
    check("held_btn_no_busy", int'(busy), 0);
    check("held_btn_level", int'(zoom_level), 0);
    btn_zoom_in = 1'b0;
    tick(5);

    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
